// File: rtl/wb_stream_sched_pkg.sv
// Shared types and constants for the Wishbone stream writer scheduler.
// Register map, CSR command values, FSM states and the descriptor bundle.
package wb_stream_sched_pkg;

  localparam logic [7:0] REG_CSR        = 8'h00;
  localparam logic [7:0] REG_START_ADDR = 8'h04;
  localparam logic [7:0] REG_BUF_SIZE   = 8'h08;
  localparam logic [7:0] REG_BURST_SIZE = 8'h0C;

  localparam logic [31:0] CSR_ENABLE  = 32'd1;
  localparam logic [31:0] CSR_IRQ_CLR = 32'd2;
  localparam logic [31:0] CSR_DISABLE = 32'd0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR_START,
    ST_WR_SIZE,
    ST_WR_BURST,
    ST_WR_EN,
    ST_WAIT_IRQ,
    ST_WR_CLR,
    ST_WR_DIS,
    ST_RETIRE
  } sched_state_e;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] size;
    logic [7:0]  burst;
  } desc_t;

  // A descriptor is usable when it moves a whole number of bursts.
  function automatic logic desc_ok(desc_t d);
    logic [31:0] unit;
    unit = {22'd0, d.burst, 2'b00};
    return (d.size != 32'd0) && (d.burst >= 8'd2) &&
           ((d.size % unit) == 32'd0);
  endfunction

endpackage

// File: rtl/sched_desc_fifo.sv
// Descriptor queue for the stream writer scheduler.
// Synchronous FIFO, async active-low reset, full/empty/count.
module sched_desc_fifo
  import wb_stream_sched_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  desc_t       din_i,
  input  logic        pop_i,
  output desc_t       dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam int DEPTH = 1 << AW;

  desc_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy update.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, do_push}
                  - {{AW{1'b0}}, do_pop};
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Descriptor storage, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/wb_stream_writer_sched.sv
// Descriptor scheduler driving the stream writer's Wishbone config port.
// Optional irq watchdog: define STREAM_SCHED_TIMEOUT_EN.
module wb_stream_writer_sched
  import wb_stream_sched_pkg::*;
#(
  parameter int DESC_AW = 2,
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        desc_start_i,
  input  logic [31:0]        desc_size_i,
  input  logic [7:0]         desc_burst_i,
  input  logic               desc_valid_i,
  output logic               desc_ready_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic               irq_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [DESC_AW:0]   pending_o
);

  sched_state_e state_q, state_d;
  logic         gap_q, gap_d;
  logic         fail_q, fail_d;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  desc_t        head;
  desc_t        push_desc;
  logic         wr_state;
  logic [7:0]   reg_adr;
  logic [31:0]  reg_dat;
  logic         unused_dat;

  assign unused_dat = ^wbm_dat_i;

`ifdef STREAM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  assign push_desc = '{start: desc_start_i,
                       size:  desc_size_i,
                       burst: desc_burst_i};

  sched_desc_fifo #(.AW(DESC_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (desc_valid_i && desc_ready_o),
    .din_i   (push_desc),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_o)
  );

  assign desc_ready_o = !fifo_full;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
  assign done_o       = (state_q == ST_RETIRE);
  assign err_o        = done_o && fail_q;

  // Register address/data presented by each write state.
  always_comb begin
    wr_state = 1'b1;
    reg_adr  = REG_CSR;
    reg_dat  = CSR_DISABLE;
    unique case (state_q)
      ST_WR_START: begin
        reg_adr = REG_START_ADDR;
        reg_dat = head.start;
      end
      ST_WR_SIZE: begin
        reg_adr = REG_BUF_SIZE;
        reg_dat = head.size;
      end
      ST_WR_BURST: begin
        reg_adr = REG_BURST_SIZE;
        reg_dat = {24'd0, head.burst};
      end
      ST_WR_EN:  reg_dat = CSR_ENABLE;
      ST_WR_CLR: reg_dat = CSR_IRQ_CLR;
      ST_WR_DIS: reg_dat = CSR_DISABLE;
      default:   wr_state = 1'b0;
    endcase
  end

  assign wbm_cyc_o = wr_state && !gap_q;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_adr_o = WB_AW'(reg_adr);
  assign wbm_dat_o = WB_DW'(reg_dat);
  assign wbm_sel_o = '1;
  assign wbm_cti_o = 3'b111;
  assign wbm_bte_o = 2'b00;

  // Sequencing: check, program, wait for irq, clear, retire.
  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    fail_d  = fail_q;
    pop     = 1'b0;
`ifdef STREAM_SCHED_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        fail_d = 1'b0;
        if (!fifo_empty) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (desc_ok(head)) begin
          state_d = ST_WR_START;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_RETIRE;
        end
      end
      ST_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = ST_WR_CLR;
`ifdef STREAM_SCHED_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_WR_DIS;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      ST_RETIRE: begin
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        if (!gap_q) begin
          if (wbm_err_i) begin
            fail_d  = 1'b1;
            state_d = ST_RETIRE;
          end else if (wbm_ack_i) begin
            gap_d = 1'b1;
            unique case (state_q)
              ST_WR_START: state_d = ST_WR_SIZE;
              ST_WR_SIZE:  state_d = ST_WR_BURST;
              ST_WR_BURST: state_d = ST_WR_EN;
              ST_WR_EN:    state_d = ST_WAIT_IRQ;
              ST_WR_DIS: begin
                fail_d  = 1'b1;
                state_d = ST_RETIRE;
              end
              default:     state_d = ST_RETIRE;
            endcase
          end else if (wbm_rty_i) begin
            gap_d = 1'b1;
          end
        end
      end
    endcase
  end

  // FSM state and bus-phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      fail_q  <= fail_d;
    end
  end

`ifdef STREAM_SCHED_TIMEOUT_EN
  // Watchdog counter, live only in WAIT_IRQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_wb_stream_writer_sched.sv
// Directed bench for wb_stream_writer_sched.
// Scoreboard of expected config writes/retires plus literal checks.
module tb_wb_stream_writer_sched;

  localparam int TMO = 100;

  logic        clk;
  logic        rst;
  logic [31:0] desc_start;
  logic [31:0] desc_size;
  logic [7:0]  desc_burst;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack;
  logic        berr;
  logic        rty;
  logic        irq;
  logic        busy;
  logic        done;
  logic        errp;
  logic [2:0]  pending;

  wb_stream_writer_sched #(
    .DESC_AW(2), .WB_AW(32), .WB_DW(32), .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .desc_start_i (desc_start),
    .desc_size_i  (desc_size),
    .desc_burst_i (desc_burst),
    .desc_valid_i (desc_valid),
    .desc_ready_o (desc_ready),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat),
    .wbm_sel_o    (sel),
    .wbm_we_o     (we),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_cti_o    (cti),
    .wbm_bte_o    (bte),
    .wbm_dat_i    (rdat),
    .wbm_ack_i    (ack),
    .wbm_err_i    (berr),
    .wbm_rty_i    (rty),
    .irq_i        (irq),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (errp),
    .pending_o    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [39:0] exp_wr[$];
  bit          exp_ret[$];
  int          mcount;
  bit          done_seen;
  bit          prev_resp;
  int          pc;
  int          push_pc;
  bit          lat_armed;
  int          lat;
  int          n_acc;
  int          n_wr;
  int          n_done;
  int          n_err;
  int          cyc_cnt;
  int          done_pc;
  int          irq_dly;
  int          irq_cnt;
  int          en_pc;
  int          en_cnt;
  int          dis_pc;
  bit          stall;
  bit          err_arm;
  logic [7:0]  err_adr;
  bit          rty_arm;
  bit          rty_seen;
  int          rty_pc;
  int          reissue_pc;
  int          nxt_err_idx;
  bit          nxt_tmo;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  function automatic bit d_ok(input logic [31:0] s,
                              input logic [7:0] b);
    int unsigned unit;
    unit = 32'(b) * 4;
    if (s == 0 || b < 2) return 1'b0;
    return (s % unit) == 0;
  endfunction

  task automatic model_clear();
    exp_wr.delete();
    exp_ret.delete();
    mcount    = 0;
    done_seen = 0;
    prev_resp = 0;
    irq       = 0;
    irq_cnt   = -1;
    ack       = 0;
    berr      = 0;
    rty       = 0;
  endtask

  // Negedge: check outputs and act as the writer's config slave.
  task automatic mon();
    bit a;
    bit e;
    bit r;
    a = 0;
    e = 0;
    r = 0;
    chk("bus_const", 64'({sel, cti, bte, we, stb}),
        64'({4'hF, 3'd7, 2'd0, cyc, cyc}));
    chk("pending", 64'(pending), 64'(mcount));
    chk("ready", 64'(desc_ready), 64'(mcount < 4));
    if (prev_resp) chk("gap", 64'(cyc), 64'd0);
    if (mcount == 0 || cyc) chk("busy", 64'(busy), 64'(mcount != 0));
    if (done) begin
      done_pc = pc;
      n_done++;
      if (errp) n_err++;
      if (exp_ret.size() == 0) chk("done_unexp", 64'(done), 64'd0);
      else chk("done_err", 64'(errp), 64'(exp_ret.pop_front()));
    end else begin
      chk("err_alone", 64'(errp), 64'd0);
    end
    if (irq_cnt > 0) irq_cnt--;
    if (irq_cnt == 0) begin
      irq = 1;
      irq_cnt = -1;
    end
    if (cyc && stb) begin
      cyc_cnt++;
      if (lat_armed) begin
        lat = pc - push_pc;
        lat_armed = 0;
      end
      if (stall) begin
      end else if (err_arm && adr[7:0] == err_adr) begin
        e = 1;
        err_arm = 0;
      end else if (rty_arm && adr == 0 && dat == 1) begin
        r = 1;
        rty_arm = 0;
        rty_seen = 1;
        rty_pc = pc;
      end else begin
        a = 1;
        n_wr++;
        if (exp_wr.size() == 0) chk("wr_unexp", 64'(cyc), 64'd0);
        else chk("wr", {adr, dat}, {24'd0, exp_wr.pop_front()});
        if (adr == 0 && dat == 1) begin
          if (rty_seen) begin
            reissue_pc = pc;
            rty_seen = 0;
          end
          en_pc = pc;
          en_cnt++;
          irq_cnt = irq_dly;
        end
        if (adr == 0 && dat == 2) irq = 0;
        if (adr == 0 && dat == 0) dis_pc = pc;
      end
    end
    ack = a;
    berr = e;
    rty = r;
    prev_resp = cyc && (a || e || r);
    done_seen = done;
  endtask

  // Posedge: queue model; expected writes derived from descriptor.
  task automatic mpos();
    bit acc;
    bit ok;
    logic [39:0] l[5];
    int n;
    pc++;
    acc = desc_valid && rst && (mcount < 4);
    if (acc) begin
      ok = d_ok(desc_size, desc_burst);
      l[0] = {8'h04, desc_start};
      l[1] = {8'h08, desc_size};
      l[2] = {8'h0C, 24'd0, desc_burst};
      l[3] = {8'h00, 32'd1};
      l[4] = nxt_tmo ? {8'h00, 32'd0} : {8'h00, 32'd2};
      n = !ok ? 0 : (nxt_err_idx >= 0 ? nxt_err_idx : 5);
      for (int i = 0; i < n; i++) exp_wr.push_back(l[i]);
      exp_ret.push_back(!ok || nxt_err_idx >= 0 || nxt_tmo);
      push_pc = pc;
      lat_armed = 1;
      n_acc++;
    end
    mcount = mcount + int'(acc) - int'(done_seen);
    done_seen = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    mpos();
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] sz,
                      input logic [7:0] b, input int ei,
                      input bit to);
    int a0;
    a0 = n_acc;
    desc_start = s;
    desc_size = sz;
    desc_burst = b;
    nxt_err_idx = ei;
    nxt_tmo = to;
    desc_valid = 1;
    for (int i = 0; i < 200 && n_acc == a0; i++) tick();
    if (n_acc == a0) chk("push_bound", 64'(n_acc), 64'(a0 + 1));
    desc_valid = 0;
    nxt_err_idx = -1;
    nxt_tmo = 0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while ((mcount != 0 || exp_ret.size() != 0) && i < bound) begin
      tick();
      i++;
    end
    if (i >= bound) chk("idle_bound", 64'(mcount), 64'd0);
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
  endtask

  int w0, d0, e0, c0;

  task automatic snap();
    w0 = n_wr;
    d0 = n_done;
    e0 = n_err;
    c0 = cyc_cnt;
  endtask

  initial begin
    n_pass = 0; n_total = 0; pc = 0; n_acc = 0; n_wr = 0;
    n_done = 0; n_err = 0; cyc_cnt = 0; lat = -1; done_pc = 0;
    push_pc = 0; lat_armed = 0; en_pc = 0; en_cnt = 0; dis_pc = 0;
    stall = 0; err_arm = 0; err_adr = 8'h00; rty_arm = 0;
    rty_seen = 0; rty_pc = 0; reissue_pc = 0; irq_dly = 20;
    nxt_err_idx = -1; nxt_tmo = 0; rdat = 32'h0;
    desc_start = 0; desc_size = 0; desc_burst = 0; desc_valid = 0;
    rst = 0;
    model_clear();
    #1;
    chk("rst_bus", 64'({adr, cyc, stb, we, bte}), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_sel", 64'({sel, cti}), 64'h7F);
    chk("rst_stat", 64'({busy, done, errp}), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_ready", 64'(desc_ready), 64'd1);
    tick();
    tick();
    rst = 1;
    tick();

    // single clean descriptor
    snap();
    irq_dly = 20;
    push(32'h40, 32'd64, 8'd4, -1, 0);
    wait_idle(300);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_writes", 64'(n_wr - w0), 64'd5);
    chk("t1_done", 64'(n_done - d0), 64'd1);
    chk("t1_err", 64'(n_err - e0), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // fill the queue with the writer stalled
    snap();
    stall = 1;
    irq_dly = 3;
    push(32'h100, 32'd32, 8'd2, -1, 0);
    push(32'h200, 32'd32, 8'd2, -1, 0);
    push(32'h300, 32'd32, 8'd2, -1, 0);
    push(32'h400, 32'd32, 8'd2, -1, 0);
    desc_start = 32'h500;
    desc_valid = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_ready", 64'(desc_ready), 64'd0);
    chk("t2_pend", 64'(pending), 64'd4);
    desc_valid = 0;
    stall = 0;
    wait_idle(600);
    chk("t2_done", 64'(n_done - d0), 64'd4);
    chk("t2_writes", 64'(n_wr - w0), 64'd20);

    // rejected descriptor
    snap();
    push(32'h800, 32'd60, 8'd4, -1, 0);
    wait_idle(50);
    chk("t3_cyc", 64'(cyc_cnt - c0), 64'd0);
    chk("t3_err", 64'(n_err - e0), 64'd1);
    chk("t3_lat", 64'((done_pc - push_pc) <= 3), 64'd1);

    // bus error on the size write, then a clean one
    snap();
    irq_dly = 5;
    err_arm = 1;
    err_adr = 8'h08;
    push(32'h1000, 32'd16, 8'd2, 1, 0);
    push(32'h2000, 32'd128, 8'd8, -1, 0);
    wait_idle(300);
    chk("t4_writes", 64'(n_wr - w0), 64'd6);
    chk("t4_done", 64'(n_done - d0), 64'd2);
    chk("t4_err", 64'(n_err - e0), 64'd1);

    // one retry on the enable write
    snap();
    rty_arm = 1;
    push(32'h3000, 32'd256, 8'd16, -1, 0);
    wait_idle(300);
    chk("t5_reissue", 64'(reissue_pc - rty_pc), 64'd2);
    chk("t5_writes", 64'(n_wr - w0), 64'd5);
    chk("t5_err", 64'(n_err - e0), 64'd0);

    // async reset while waiting for irq
    irq_dly = 1000;
    c0 = en_cnt;
    push(32'h5000, 32'd64, 8'd4, -1, 0);
    for (int i = 0; i < 100 && en_cnt == c0; i++) tick();
    chk("t6_en", 64'(en_cnt - c0), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 0;
    #1;
    chk("t6_cyc", 64'(cyc), 64'd0);
    chk("t6_pend", 64'(pending), 64'd0);
    chk("t6_stat", 64'({busy, done, errp, desc_ready}), 64'd1);
    model_clear();
    tick();
    tick();
    rst = 1;
    snap();
    irq_dly = 4;
    push(32'h6000, 32'd64, 8'd4, -1, 0);
    wait_idle(300);
    chk("t6_writes", 64'(n_wr - w0), 64'd5);
    chk("t6_err", 64'(n_err - e0), 64'd0);

`ifdef STREAM_SCHED_TIMEOUT_EN
    // watchdog fires with no irq
    snap();
    irq_dly = -1;
    push(32'h7000, 32'd64, 8'd4, -1, 1);
    wait_idle(500);
    chk("t7_wait", 64'(dis_pc - en_pc - 1), 64'(TMO));
    chk("t7_err", 64'(n_err - e0), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
